// File: rtl/phy_tx_lane_sched_pkg.sv
// rtl/phy_tx_lane_sched_pkg.sv - shared types and constants for the tx lane scheduler
package phy_tx_lane_sched_pkg;

  localparam int LANES  = 4;
  localparam int BYTE_W = 8;

  localparam logic [BYTE_W-1:0] COMMA_SYM = 8'hBC;
  localparam logic [BYTE_W-1:0] IDLE_SYM  = 8'h7C;

  typedef enum logic [1:0] {
    ST_RST    = 2'd0,
    ST_SYNC   = 2'd1,
    ST_ACTIVE = 2'd2
  } link_state_t;

endpackage

// File: rtl/phy_tx_lane_fifo.sv
// rtl/phy_tx_lane_fifo.sv - per-lane synchronous FIFO with sticky overflow flag
// Show-ahead read port: o_rd_data is the head entry whenever the FIFO is non-empty.
module phy_tx_lane_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_wr_en,
  input  logic [WIDTH-1:0]         i_wr_data,
  input  logic                     i_rd_en,
  output logic [WIDTH-1:0]         o_rd_data,
  output logic                     o_empty,
  output logic                     o_full,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_overflow;

  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_push;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CW'(DEPTH));
  assign w_pop   = i_rd_en && !w_empty;
  // A pop frees the slot in the same cycle, so a full FIFO still accepts a write
  assign w_push  = i_wr_en && (!w_full || w_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (i_wr_en && !w_push) r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wr_data;
  end

  assign o_rd_data  = r_mem[r_rd_ptr];
  assign o_empty    = w_empty;
  assign o_full     = w_full;
  assign o_count    = r_count;
  assign o_overflow = r_overflow;

endmodule

// File: rtl/phy_tx_lane_sched.sv
// rtl/phy_tx_lane_sched.sv - four-lane transmit scheduler: comma sync then round-robin byte stream
// Link stays in SYNC emitting commas until the receiver reports lock for SYNC_COUNT cycles.
module phy_tx_lane_sched
  import phy_tx_lane_sched_pkg::*;
#(
  parameter int                FIFO_DEPTH = 4,
  parameter int                SYNC_COUNT = 4,
  parameter logic [BYTE_W-1:0] COMMA      = COMMA_SYM,
  parameter logic [BYTE_W-1:0] IDLE       = IDLE_SYM
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [LANES*BYTE_W-1:0]   i_data,
  input  logic [LANES-1:0]          i_valid,
  input  logic                      i_recirculacion,
  output logic [LANES-1:0]          o_pause,
  output logic [LANES-1:0]          o_overflow,
  output logic [BYTE_W-1:0]         o_data,
  output logic                      o_valid,
  output logic [$clog2(LANES)-1:0]  o_lane_id,
  output logic [1:0]                o_link_state
);

  localparam int LW    = $clog2(LANES);
  localparam int CW    = $clog2(FIFO_DEPTH) + 1;
  localparam int CNT_W = $clog2(SYNC_COUNT + 1);

  link_state_t        r_state;
  logic [CNT_W-1:0]   r_sync_cnt;
  logic [LW-1:0]      r_rr;
  logic [BYTE_W-1:0]  r_data;
  logic               r_valid;
  logic [LW-1:0]      r_lane_id;

  logic [BYTE_W-1:0]  w_rd_data [LANES];
  logic [CW-1:0]      w_count   [LANES];
  logic [LANES-1:0]   w_empty;
  logic [LANES-1:0]   w_full;
  logic [LANES-1:0]   w_rd_en;
  logic               w_grant;
  logic [LW-1:0]      w_win;
  logic [LW-1:0]      w_idx;
  logic               w_pop_ok;

  genvar g;
  generate
    for (g = 0; g < LANES; g++) begin : g_lane
      phy_tx_lane_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (BYTE_W)
      ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_wr_en    (i_valid[g]),
        .i_wr_data  (i_data[g*BYTE_W +: BYTE_W]),
        .i_rd_en    (w_rd_en[g]),
        .o_rd_data  (w_rd_data[g]),
        .o_empty    (w_empty[g]),
        .o_full     (w_full[g]),
        .o_count    (w_count[g]),
        .o_overflow (o_overflow[g])
      );

      assign w_rd_en[g] = w_pop_ok && (w_win == LW'(g));
      assign o_pause[g] = w_full[g] || (w_count[g] == CW'(FIFO_DEPTH - 1));
    end
  endgenerate

  // First non-empty lane after the last winner, wrapping back to the last winner itself
  always_comb begin
    w_grant = 1'b0;
    w_win   = r_rr;
    w_idx   = r_rr;
    for (int k = 1; k <= LANES; k++) begin
      w_idx = r_rr + LW'(k);
      if (!w_grant && !w_empty[w_idx]) begin
        w_grant = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  assign w_pop_ok = (r_state == ST_ACTIVE) && !i_recirculacion && w_grant;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_RST;
      r_sync_cnt <= '0;
      r_rr       <= LW'(LANES - 1);
      r_data     <= COMMA;
      r_valid    <= 1'b0;
      r_lane_id  <= '0;
    end else begin
      case (r_state)
        ST_RST: begin
          r_state <= ST_SYNC;
          r_data  <= COMMA;
          r_valid <= 1'b0;
        end
        ST_SYNC: begin
          r_data  <= COMMA;
          r_valid <= 1'b0;
          if (i_recirculacion) begin
            r_sync_cnt <= '0;
          end else if (r_sync_cnt == CNT_W'(SYNC_COUNT - 1)) begin
            r_state    <= ST_ACTIVE;
            r_sync_cnt <= '0;
          end else begin
            r_sync_cnt <= r_sync_cnt + CNT_W'(1);
          end
        end
        ST_ACTIVE: begin
          if (i_recirculacion) begin
            r_state    <= ST_SYNC;
            r_sync_cnt <= '0;
            r_data     <= COMMA;
            r_valid    <= 1'b0;
          end else if (w_grant) begin
            r_data    <= w_rd_data[w_win];
            r_valid   <= 1'b1;
            r_lane_id <= w_win;
            r_rr      <= w_win;
          end else begin
            r_data  <= IDLE;
            r_valid <= 1'b0;
          end
        end
        default: r_state <= ST_RST;
      endcase
    end
  end

  assign o_data       = r_data;
  assign o_valid      = r_valid;
  assign o_lane_id    = r_lane_id;
  assign o_link_state = r_state;

endmodule

// File: tb/tb_phy_tx_lane_sched.sv
// tb/tb_phy_tx_lane_sched.sv - self-checking bench for phy_tx_lane_sched
// Directed link scenarios followed by random traffic, all checked against a queue-based model.
module tb_phy_tx_lane_sched;

  localparam int SYNC_COUNT = 4;
  localparam int DEPTH      = 4;

  logic        clk;
  logic        rst_n;
  logic [31:0] i_data;
  logic [3:0]  i_valid;
  logic        i_recirc;
  logic [3:0]  o_pause;
  logic [3:0]  o_overflow;
  logic [7:0]  o_data;
  logic        o_valid;
  logic [1:0]  o_lane_id;
  logic [1:0]  o_link_state;

  phy_tx_lane_sched #(
    .FIFO_DEPTH (DEPTH),
    .SYNC_COUNT (SYNC_COUNT)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_data          (i_data),
    .i_valid         (i_valid),
    .i_recirculacion (i_recirc),
    .o_pause         (o_pause),
    .o_overflow      (o_overflow),
    .o_data          (o_data),
    .o_valid         (o_valid),
    .o_lane_id       (o_lane_id),
    .o_link_state    (o_link_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef logic [7:0] byte_q_t [$];
  byte_q_t     mq [4];
  int          m_state;
  int          m_zeros;
  int          m_rr;
  logic [7:0]  m_data;
  logic        m_valid;
  int          m_lane;
  logic [3:0]  m_ovf;

  int n_checks;
  int n_fail;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int l = 0; l < 4; l++) mq[l].delete();
    m_state = 0;
    m_zeros = 0;
    m_rr    = 3;
    m_data  = 8'hBC;
    m_valid = 1'b0;
    m_lane  = 0;
    m_ovf   = 4'h0;
  endtask

  task automatic model_step(input logic [31:0] d, input logic [3:0] v, input logic rc);
    int win;
    int l;
    win = -1;
    if (m_state == 2 && !rc) begin
      for (int k = 1; k <= 4; k++) begin
        l = (m_rr + k) % 4;
        if (win < 0 && mq[l].size() > 0) win = l;
      end
    end
    case (m_state)
      0: begin
        m_state = 1;
        m_data  = 8'hBC;
        m_valid = 1'b0;
      end
      1: begin
        m_data  = 8'hBC;
        m_valid = 1'b0;
        if (rc) m_zeros = 0;
        else begin
          m_zeros++;
          if (m_zeros == SYNC_COUNT) begin
            m_state = 2;
            m_zeros = 0;
          end
        end
      end
      default: begin
        if (rc) begin
          m_state = 1;
          m_data  = 8'hBC;
          m_valid = 1'b0;
        end else if (win >= 0) begin
          m_data  = mq[win].pop_front();
          m_valid = 1'b1;
          m_lane  = win;
          m_rr    = win;
        end else begin
          m_data  = 8'h7C;
          m_valid = 1'b0;
        end
      end
    endcase
    for (int n = 0; n < 4; n++) begin
      if (v[n]) begin
        if (mq[n].size() < DEPTH) mq[n].push_back(d[8*n +: 8]);
        else m_ovf[n] = 1'b1;
      end
    end
  endtask

  task automatic check_outputs();
    logic [3:0] exp_pause;
    for (int n = 0; n < 4; n++) exp_pause[n] = (mq[n].size() >= DEPTH - 1);
    check_eq("link_state", 32'(o_link_state), 32'(m_state));
    check_eq("data_out", 32'(o_data), 32'(m_data));
    check_eq("valid_out", 32'(o_valid), 32'(m_valid));
    if (m_valid) check_eq("lane_id", 32'(o_lane_id), 32'(m_lane));
    check_eq("pause", 32'(o_pause), 32'(exp_pause));
    check_eq("overflow", 32'(o_overflow), 32'(m_ovf));
  endtask

  task automatic cycle(input logic [31:0] d, input logic [3:0] v, input logic rc);
    i_data   = d;
    i_valid  = v;
    i_recirc = rc;
    model_step(d, v, rc);
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic idle(input int n, input logic rc);
    for (int i = 0; i < n; i++) cycle(32'h0, 4'h0, rc);
  endtask

  task automatic random_traffic(input int n, input bit sparse);
    logic [3:0] v;
    for (int i = 0; i < n; i++) begin
      v = sparse ? 4'($urandom & $urandom) : 4'($urandom);
      cycle($urandom, v, $urandom_range(0, 24) == 0);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    i_data   = '0;
    i_valid  = '0;
    i_recirc = 1'b1;
    model_reset();

    #12;
    check_eq("rst_state", 32'(o_link_state), 32'd0);
    check_eq("rst_data", 32'(o_data), 32'hBC);
    check_eq("rst_valid", 32'(o_valid), 32'd0);
    check_eq("rst_pause", 32'(o_pause), 32'd0);
    check_eq("rst_ovf", 32'(o_overflow), 32'd0);
    rst_n = 1'b1;

    // Held unsynced: commas only
    idle(10, 1'b1);
    check_eq("t1_sync", 32'(o_link_state), 32'd1);

    // Lane 1 overfilled while still in SYNC
    for (int i = 0; i < 5; i++) begin
      cycle({16'h0, 8'(8'h10 + i), 8'h0}, 4'b0010, 1'b1);
      if (i == 1) check_eq("t4_pause_lo", 32'(o_pause[1]), 32'd0);
      if (i == 2) check_eq("t4_pause_hi", 32'(o_pause[1]), 32'd1);
    end
    check_eq("t4_ovf", 32'(o_overflow[1]), 32'd1);

    // Lock with a one-cycle blip at count 2
    idle(2, 1'b0);
    idle(1, 1'b1);
    idle(3, 1'b0);
    check_eq("t2_not_yet", 32'(o_link_state), 32'd1);
    idle(1, 1'b0);
    check_eq("t2_active", 32'(o_link_state), 32'd2);
    idle(6, 1'b0);

    // Multi-lane round robin
    cycle({8'h31, 8'h21, 8'h00, 8'h01}, 4'b1101, 1'b0);
    cycle({24'h0, 8'h02}, 4'b0001, 1'b0);
    idle(6, 1'b0);
    check_eq("t3_idle_data", 32'(o_data), 32'h7C);
    check_eq("t3_idle_valid", 32'(o_valid), 32'd0);

    // Full lane 0, write and pop together, then lose lock briefly
    for (int i = 0; i < 4; i++) cycle({24'h0, 8'(8'h40 + i)}, 4'b0001, 1'b1);
    idle(4, 1'b0);
    check_eq("t5_active", 32'(o_link_state), 32'd2);
    cycle({24'h0, 8'h50}, 4'b0001, 1'b0);
    check_eq("t5_no_ovf", 32'(o_overflow[0]), 32'd0);
    check_eq("t5_pause", 32'(o_pause[0]), 32'd1);
    cycle({24'h0, 8'h51}, 4'b0001, 1'b0);
    cycle({24'h0, 8'h52}, 4'b0001, 1'b0);
    idle(1, 1'b1);
    check_eq("t5_comma", 32'(o_data), 32'hBC);
    idle(4, 1'b0);
    idle(8, 1'b0);

    random_traffic(300, 1'b0);
    random_traffic(100, 1'b1);

    // Asynchronous reset between edges
    #3;
    rst_n = 1'b0;
    #1;
    check_eq("t6_state", 32'(o_link_state), 32'd0);
    check_eq("t6_data", 32'(o_data), 32'hBC);
    check_eq("t6_valid", 32'(o_valid), 32'd0);
    check_eq("t6_pause", 32'(o_pause), 32'd0);
    check_eq("t6_ovf", 32'(o_overflow), 32'd0);
    check_eq("t6_lane", 32'(o_lane_id), 32'd0);
    model_reset();
    i_valid = 4'h0;
    #2;
    rst_n = 1'b1;

    idle(1, 1'b1);
    idle(SYNC_COUNT + 3, 1'b0);
    check_eq("t6_empty", 32'(o_valid), 32'd0);
    random_traffic(200, 1'b1);
    idle(12, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
